// File: rtl/jt49_env.sv
// JT49 envelope generator: period counter, step counter and CONT/ATT/ALT/HOLD shape control.
// Optional macro JT49_ENV_STEP_EN adds env_step, a one-clk pulse on every step event.
module jt49_env #(
  parameter int ENV_BITS = 5,
  parameter int PER_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cen,
  input  logic [PER_W-1:0]    period,
  input  logic [3:0]          shape,
  input  logic                restart,
  output logic [ENV_BITS-1:0] env,
  output logic                env_stop
`ifdef JT49_ENV_STEP_EN
  ,
  output logic                env_step
`endif
);

  localparam logic [ENV_BITS-1:0] STEP_MAX = '1;

  logic [PER_W-1:0]    r_ctr;
  logic [ENV_BITS-1:0] r_step;
  logic                r_inv;
  logic [3:0]          r_shape;
  logic                r_stop;
  logic                r_zero;
  logic [ENV_BITS-1:0] r_env;

  logic [PER_W-1:0]    w_perM1;
  logic                w_tick;
  logic                w_stepEv;
  logic [PER_W-1:0]    w_ctrNxt;
  logic [ENV_BITS-1:0] w_stepNxt;
  logic                w_invNxt;
  logic [3:0]          w_shapeNxt;
  logic                w_stopNxt;
  logic                w_zeroNxt;
  logic [ENV_BITS-1:0] w_envNxt;

  // A zero period behaves as one; >= lets a shortened period step immediately.
  assign w_perM1  = (period == '0) ? '0 : period - PER_W'(1);
  assign w_tick   = cen && !r_stop;
  assign w_stepEv = w_tick && !restart && (r_ctr >= w_perM1);

  always_comb begin
    w_ctrNxt   = r_ctr;
    w_stepNxt  = r_step;
    w_invNxt   = r_inv;
    w_shapeNxt = r_shape;
    w_stopNxt  = r_stop;
    w_zeroNxt  = r_zero;
    if (restart) begin
      w_shapeNxt = shape;
      w_ctrNxt   = '0;
      w_stepNxt  = '0;
      w_invNxt   = ~shape[2];
      w_stopNxt  = 1'b0;
      w_zeroNxt  = 1'b0;
    end else if (w_tick) begin
      if (w_stepEv) begin
        w_ctrNxt = '0;
        if (r_step != STEP_MAX) begin
          w_stepNxt = r_step + ENV_BITS'(1);
        end else if (!r_shape[3]) begin
          w_stopNxt = 1'b1;
          w_zeroNxt = 1'b1;
        end else if (r_shape[0]) begin
          w_stopNxt = 1'b1;
          w_invNxt  = r_inv ^ r_shape[1];
        end else begin
          w_stepNxt = '0;
          w_invNxt  = r_inv ^ r_shape[1];
        end
      end else begin
        w_ctrNxt = r_ctr + PER_W'(1);
      end
    end
  end

  // The output register is fed from next-state values so env moves on the same edge as step.
  assign w_envNxt = w_zeroNxt ? '0 : (w_stepNxt ^ {ENV_BITS{w_invNxt}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctr   <= '0;
      r_step  <= '0;
      r_inv   <= 1'b0;
      r_shape <= '0;
      r_stop  <= 1'b1;
      r_zero  <= 1'b1;
      r_env   <= '0;
    end else begin
      r_ctr   <= w_ctrNxt;
      r_step  <= w_stepNxt;
      r_inv   <= w_invNxt;
      r_shape <= w_shapeNxt;
      r_stop  <= w_stopNxt;
      r_zero  <= w_zeroNxt;
      r_env   <= w_envNxt;
    end
  end

  assign env      = r_env;
  assign env_stop = r_stop;

`ifdef JT49_ENV_STEP_EN
  logic r_stepPulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stepPulse <= 1'b0;
    else     r_stepPulse <= w_stepEv;
  end

  assign env_step = r_stepPulse;
`endif

endmodule
